conv_layer_seq: RTL and testbench
=================================

Name: conv_layer_seq

Overview:
- Time-multiplexed, parametrised successor to the combinational LeNet final conv stage.
- Computes KNUM output points, each a full CH x WIN x WIN dot product of one input window with one kernel, using a single signed MAC.
- Sits between the pooled feature-map stage and the classifier; a start/busy/done handshake lets a controller sequence layers.

Parameters:
- BITWIDTH, 16, signed fixed-point word width of inputs and outputs.
- FRAC, 14, fractional bits of the Q format (1.0 = 2^FRAC).
- CH, 2, input channels.
- WIN, 5, window/kernel side length.
- KNUM, 10, number of kernels, which is also the number of outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- featuremap  input  BITWIDTH x [CH][WIN][WIN]  signed input window; must be held stable from the start edge until done.
- kernel  input  BITWIDTH x [KNUM][CH][WIN][WIN]  signed weights; same stability rule as featuremap.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when all outputs are written.
- featuremap_out  output  BITWIDTH x [KNUM]  registered signed results; values hold between runs.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state=IDLE, all counters 0, acc 0, busy 0, done 0, every featuremap_out[k] 0.
  - Reset mid-run aborts the run; no partial results are kept.
- Definitions:
  - T = CH*WIN*WIN terms per kernel (50 with defaults).
  - Term order: c outermost, then row, then col; k outer to all of them.
  - acc width = 2*BITWIDTH + clog2(T), signed.
- FSM states: IDLE, MAC, WRITE, DONE.
  - IDLE: start=1 at an edge -> MAC; k, c, r, col and acc cleared. start=0 -> stay.
  - MAC: each edge does acc += featuremap[c][r][col] * kernel[k][c][r][col] (full 2*BITWIDTH signed product) and advances the term counter. The edge that accumulates term T-1 -> WRITE.
  - WRITE: the edge writes featuremap_out[k] = (acc >>> FRAC) reduced to BITWIDTH and clears acc.
    - Arithmetic shift, so rounding is toward -inf.
    - Reduction wraps (keeps the low bits) unless CONV_SAT_EN is defined.
    - k == KNUM-1 -> DONE; otherwise k++ and -> MAC.
  - DONE: done=1 for exactly this cycle; next edge -> IDLE.
- Latency:
  - The start edge is E0. done is high in the cycle following edge E0 + KNUM*(T+1): edge 510 with defaults.
  - busy is high from the cycle after E0 through the done cycle.
- start while busy (MAC/WRITE/DONE) is ignored, with no queuing.
- start high in the first IDLE cycle after done begins a new run: back-to-back runs are allowed.
- featuremap_out[k] for index k changes only at its own WRITE edge. Outputs not yet rewritten keep their previous-run values during a run.
- Inputs that change while busy produce undefined results; the bench must not do this except deliberately.

Optional Feature:
- Macro: CONV_SAT_EN.
- Defined: at WRITE, the shifted accumulator saturates to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1], i.e. [-32768, 32767] at defaults.
- Undefined: two's-complement wrap to BITWIDTH bits.
- All other behaviour and timing are identical in both builds.

Test Plan:
- Basic run: featuremap all 16384 (1.0). kernel[k][0][0][0] = k*1024, all other kernel words 0. Pulse start -> done in the cycle after edge 510, featuremap_out[k] = k*1024 for k=0..9, busy low after done.
- Overflow: featuremap all 8192, kernel all 8192 (each product 0.25, sum 12.5 -> 204800).
  - Without CONV_SAT_EN: every featuremap_out = 8192 (wrapped).
  - With CONV_SAT_EN: every featuremap_out = 32767.
- Sign and rounding:
  - featuremap[0][0][0]=1, kernel[k][0][0][0]=-1, all other words 0 -> every output = -1 (floor behaviour).
  - featuremap all -16384, kernel[k][1][4][4]=16384, all other kernel words 0 -> every output = -16384.
- Handshake: extra start pulses at cycles 5 and 300 of a run -> ignored; done pulses once at edge 510 for exactly 1 cycle. start asserted in the first IDLE cycle after done -> second run's done follows at +511 edges.
- Reset mid-run: rst_n low at cycle 200 -> busy, done and all featuremap_out go 0 immediately without a clock edge. After release, a start completes the basic-run case with correct values at edge 510.

Source files
------------

// File: rtl/conv_layer_seq.sv
// Sequential conv stage: KNUM dot products of a CH x WIN x WIN window, one signed MAC per clock.
// Optional build macro CONV_SAT_EN saturates results at write-back instead of wrapping them.
module conv_layer_seq #(
    parameter int BITWIDTH = 16,
    parameter int FRAC     = 14,
    parameter int CH       = 2,
    parameter int WIN      = 5,
    parameter int KNUM     = 10
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    input  logic [CH-1:0][WIN-1:0][WIN-1:0][BITWIDTH-1:0]          featuremap,
    input  logic [KNUM-1:0][CH-1:0][WIN-1:0][WIN-1:0][BITWIDTH-1:0] kernel,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [KNUM-1:0][BITWIDTH-1:0]                          featuremap_out
);

    localparam int T    = CH * WIN * WIN;
    localparam int TW   = $clog2(T);
    localparam int ACCW = 2 * BITWIDTH + TW;
    localparam int KW   = (KNUM > 1) ? $clog2(KNUM) : 1;
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int RW   = (WIN > 1) ? $clog2(WIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [CW-1:0]                   c_q, c_d;
    logic [RW-1:0]                   r_q, r_d;
    logic [RW-1:0]                   col_q, col_d;
    logic signed [ACCW-1:0]          acc_q, acc_d;
    logic [KNUM-1:0][BITWIDTH-1:0]   featuremap_out_q, featuremap_out_d;

    logic [BITWIDTH-1:0]             fm_word;
    logic [BITWIDTH-1:0]             kn_word;
    logic signed [2*BITWIDTH-1:0]    prod;
    logic [BITWIDTH-1:0]             wr_val;
    logic                            col_last, r_last, c_last, k_last;

    assign fm_word  = featuremap[c_q][r_q][col_q];
    assign kn_word  = kernel[k_q][c_q][r_q][col_q];
    assign prod     = $signed(fm_word) * $signed(kn_word);

    assign col_last = (col_q == RW'(WIN - 1));
    assign r_last   = (r_q == RW'(WIN - 1));
    assign c_last   = (c_q == CW'(CH - 1));
    assign k_last   = (k_q == KW'(KNUM - 1));

`ifdef CONV_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
    logic signed [ACCW-1:0] shifted;

    always_comb begin
        shifted = acc_q >>> FRAC;
        if (shifted > SAT_MAX) begin
            wr_val = SAT_MAX[BITWIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            wr_val = SAT_MIN[BITWIDTH-1:0];
        end else begin
            wr_val = shifted[BITWIDTH-1:0];
        end
    end
`else
    // Arithmetic shift floors toward -inf; truncation keeps the low word (two's-complement wrap).
    always_comb begin
        wr_val = BITWIDTH'(acc_q >>> FRAC);
    end
`endif

    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        c_d              = c_q;
        r_d              = r_q;
        col_d            = col_q;
        acc_d            = acc_q;
        featuremap_out_d = featuremap_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    k_d     = '0;
                    c_d     = '0;
                    r_d     = '0;
                    col_d   = '0;
                    acc_d   = '0;
                end
            end

            S_MAC: begin
                acc_d = acc_q + {{TW{prod[2*BITWIDTH-1]}}, prod};
                if (col_last) begin
                    col_d = '0;
                    if (r_last) begin
                        r_d = '0;
                        if (c_last) begin
                            c_d     = '0;
                            state_d = S_WRITE;
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + RW'(1);
                end
            end

            S_WRITE: begin
                featuremap_out_d[k_q] = wr_val;
                acc_d                 = '0;
                if (k_last) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_MAC;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            k_q              <= '0;
            c_q              <= '0;
            r_q              <= '0;
            col_q            <= '0;
            acc_q            <= '0;
            featuremap_out_q <= '0;
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            c_q              <= c_d;
            r_q              <= r_d;
            col_q            <= col_d;
            acc_q            <= acc_d;
            featuremap_out_q <= featuremap_out_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign featuremap_out = featuremap_out_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: vector table of runs plus handshake and mid-run reset sequences.
module tb_conv_layer_seq;

    localparam int BW   = 16;
    localparam int FRAC = 14;
    localparam int CH   = 2;
    localparam int WIN  = 5;
    localparam int KNUM = 10;
    localparam int LAT  = KNUM * (CH * WIN * WIN + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [CH-1:0][WIN-1:0][WIN-1:0][BW-1:0]           fm;
    logic [KNUM-1:0][CH-1:0][WIN-1:0][WIN-1:0][BW-1:0] kn;
    logic busy;
    logic done;
    logic [KNUM-1:0][BW-1:0] fout;

    int errors = 0;
    int checks = 0;

    conv_layer_seq #(
        .BITWIDTH(BW), .FRAC(FRAC), .CH(CH), .WIN(WIN), .KNUM(KNUM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .featuremap(fm),
        .kernel(kn),
        .busy(busy),
        .done(done),
        .featuremap_out(fout)
    );

    always #5 clk = ~clk;

    // kmode: 0 = kernel[k][0][0][0]=k*kval, 1 = all words kval,
    //        2 = kernel[k][0][0][0]=kval,   3 = kernel[k][1][4][4]=kval
    typedef struct {
        string name;
        int    fm_val;
        bit    fm_single;
        int    kmode;
        int    kval;
        int    exp_base;
        int    exp_step;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        fm = '0;
        kn = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < WIN; r++)
                for (int col = 0; col < WIN; col++) begin
                    if (!v.fm_single || (c == 0 && r == 0 && col == 0))
                        fm[c][r][col] = BW'(v.fm_val);
                    for (int k = 0; k < KNUM; k++) begin
                        case (v.kmode)
                            0: if (c == 0 && r == 0 && col == 0) kn[k][c][r][col] = BW'(k * v.kval);
                            1: kn[k][c][r][col] = BW'(v.kval);
                            2: if (c == 0 && r == 0 && col == 0) kn[k][c][r][col] = BW'(v.kval);
                            default: if (c == 1 && r == 4 && col == 4) kn[k][c][r][col] = BW'(v.kval);
                        endcase
                    end
                end
    endtask

    // Called #1 after an edge while idle; returns #1 after the edge where done is first seen.
    task automatic run(input bit extra, output int lat, output int busy_bad);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_bad = 0;
        while (1) begin
            if (!busy) busy_bad++;
            start = (extra && (lat == 5 || lat == 300)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (done || lat >= LAT + 50) break;
        end
        start = 1'b0;
    endtask

    task automatic check_outputs(input string name, input vec_t v);
        int e;
        for (int k = 0; k < KNUM; k++) begin
            e = v.exp_base + k * v.exp_step;
            check($sformatf("%s_out%0d", name, k), $signed(fout[k]), e);
        end
    endtask

    task automatic check_tail(input string name);
        check({name, "_done_busy"}, busy, 1);
        @(posedge clk);
        #1;
        check({name, "_done_width"}, done, 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int lat;
        int bb;

        vecs[0] = '{"basic",    16384, 1'b0, 0, 1024,  0,     1024};
`ifdef CONV_SAT_EN
        vecs[1] = '{"overflow", 8192,  1'b0, 1, 8192,  32767, 0};
`else
        vecs[1] = '{"overflow", 8192,  1'b0, 1, 8192,  8192,  0};
`endif
        vecs[2] = '{"floor_m1", 1,     1'b1, 2, -1,    -1,    0};
        vecs[3] = '{"neg_last", -16384, 1'b0, 3, 16384, -16384, 0};
        vecs[4] = '{"frac_pos", 3,     1'b0, 1, 5000,  45,    0};
        vecs[5] = '{"frac_neg", -3,    1'b0, 1, 5000,  -46,   0};

        rst_n = 1'b0;
        start = 1'b0;
        fm    = '0;
        kn    = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        for (int k = 0; k < KNUM; k++)
            check($sformatf("rst_out%0d", k), $signed(fout[k]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            apply_vec(vecs[i]);
            run(1'b0, lat, bb);
            check({vecs[i].name, "_latency"}, lat, LAT);
            check({vecs[i].name, "_busy_run"}, bb, 0);
            check_tail(vecs[i].name);
            check_outputs(vecs[i].name, vecs[i]);
        end

        // Extra starts while busy, then a back-to-back run started in the first idle cycle.
        apply_vec(vecs[0]);
        run(1'b1, lat, bb);
        check("hs_latency", lat, LAT);
        check("hs_busy_run", bb, 0);
        check_tail("hs");
        check_outputs("hs", vecs[0]);
        apply_vec(vecs[4]);
        run(1'b0, lat, bb);
        check("b2b_latency", lat, LAT);
        check_tail("b2b");
        check_outputs("b2b", vecs[4]);

        // Outputs must hold and update only per-kernel during a run: mid-run, k=0 rewritten, k=9 not.
        apply_vec(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("hold_out0", $signed(fout[0]), 0);
        check("hold_out9", $signed(fout[9]), 45);
        repeat (100) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        for (int k = 0; k < KNUM; k++)
            check($sformatf("arst_out%0d", k), $signed(fout[k]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1'b0, lat, bb);
        check("post_rst_latency", lat, LAT);
        check_tail("post_rst");
        check_outputs("post_rst", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
